// File: rtl/walker_anim_ctrl.sv
// Walking-man frame sequencer: advances a frame index on prescaled time-base strobes in walk phases.
// Optional blink of the figure at low countdown is built only with WALKER_BLINK_EN defined.
module walker_anim_ctrl #(
  parameter int FRAME_W      = 4,
  parameter int NUM_FRAMES   = 16,
  parameter int PHASE_W      = 3,
  parameter int PRESC_W      = 8,
  parameter int SLOW_PH      = 0,
  parameter int FAST_PH      = 1,
  parameter int SLOW_DIV     = 16,
  parameter int FAST_DIV     = 8,
  parameter int BLINK_THRESH = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PHASE_W-1:0] cur_phase,
  input  logic               minus_1,
  input  logic [3:0]         seven_num,
  output logic [FRAME_W-1:0] man_state,
  output logic               walk_active,
  output logic               frame_wrap,
  output logic               man_visible
);

  // A divider of 0 or 1 both mean "advance on every strobe".
  function automatic logic [PRESC_W-1:0] div_last(input int div);
    if (div <= 1) begin
      return {PRESC_W{1'b0}};
    end else begin
      return PRESC_W'(div - 1);
    end
  endfunction

  localparam logic [PHASE_W-1:0] SLOW_CODE  = PHASE_W'(SLOW_PH);
  localparam logic [PHASE_W-1:0] FAST_CODE  = PHASE_W'(FAST_PH);
  localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(NUM_FRAMES - 1);
  localparam logic [FRAME_W-1:0] FRAME_ONE  = {{(FRAME_W-1){1'b0}}, 1'b1};
  localparam logic [PRESC_W-1:0] PRESC_ONE  = {{(PRESC_W-1){1'b0}}, 1'b1};
  localparam logic [PRESC_W-1:0] SLOW_LAST  = div_last(SLOW_DIV);
  localparam logic [PRESC_W-1:0] FAST_LAST  = div_last(FAST_DIV);

  logic [PHASE_W-1:0] phase_q_r;
  logic [PRESC_W-1:0] presc_r;
  logic [PRESC_W-1:0] presc_last_s;
  logic               is_slow_s;
  logic               is_walk_s;
  logic               change_s;
  logic               strobe_s;
  logic               advance_s;

  // Phase decode, change detect and frame-advance qualification.
  always_comb begin
    is_slow_s = (cur_phase == SLOW_CODE);
    is_walk_s = is_slow_s || (cur_phase == FAST_CODE);
    change_s  = (cur_phase != phase_q_r);
    if (is_slow_s) begin
      presc_last_s = SLOW_LAST;
    end else begin
      presc_last_s = FAST_LAST;
    end
    strobe_s  = !change_s && is_walk_s && minus_1;
    advance_s = strobe_s && (presc_r == presc_last_s);
  end

  // Prescaler, frame counter and phase tracking; a phase change wins over a strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q_r   <= {PHASE_W{1'b1}};
      presc_r     <= {PRESC_W{1'b0}};
      man_state   <= {FRAME_W{1'b0}};
      walk_active <= 1'b0;
      frame_wrap  <= 1'b0;
    end else begin
      phase_q_r   <= cur_phase;
      walk_active <= is_walk_s;
      frame_wrap  <= 1'b0;
      if (change_s || !is_walk_s) begin
        presc_r   <= {PRESC_W{1'b0}};
        man_state <= {FRAME_W{1'b0}};
      end else if (advance_s) begin
        presc_r <= {PRESC_W{1'b0}};
        if (man_state == LAST_FRAME) begin
          man_state  <= {FRAME_W{1'b0}};
          frame_wrap <= 1'b1;
        end else begin
          man_state <= man_state + FRAME_ONE;
        end
      end else if (strobe_s) begin
        presc_r <= presc_r + PRESC_ONE;
      end else begin
        presc_r <= presc_r;
      end
    end
  end

`ifdef WALKER_BLINK_EN
  logic blink_cond_s;

  // Blinking is allowed only while walking fast with a low countdown.
  always_comb begin
    blink_cond_s = (cur_phase == FAST_CODE) && (int'(seven_num) <= BLINK_THRESH);
  end

  // The visibility register doubles as the blink toggle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      man_visible <= 1'b1;
    end else if (change_s || !blink_cond_s) begin
      man_visible <= 1'b1;
    end else if (advance_s) begin
      man_visible <= ~man_visible;
    end else begin
      man_visible <= man_visible;
    end
  end
`else
  logic unused_blink_s;

  assign unused_blink_s = (^seven_num) ^ (BLINK_THRESH > 15);
  assign man_visible    = 1'b1;
`endif

endmodule

// File: tb/tb_walker_anim_ctrl.sv
// Self-checking bench for walker_anim_ctrl: directed table, corner sequences and randomized
// traffic against a strobe-counting reference model (two instances: default and FAST_DIV=0).
module tb_walker_anim_ctrl;

`ifdef WALKER_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] cur_phase;
  logic       minus_1;
  logic [3:0] seven_num;
  logic [3:0] man0, man1;
  logic       walk0, walk1, wrap0, wrap1, vis0, vis1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  walker_anim_ctrl dut0 (
    .clk(clk), .rst(rst), .cur_phase(cur_phase), .minus_1(minus_1), .seven_num(seven_num),
    .man_state(man0), .walk_active(walk0), .frame_wrap(wrap0), .man_visible(vis0)
  );

  walker_anim_ctrl #(.FAST_DIV(0)) dut1 (
    .clk(clk), .rst(rst), .cur_phase(cur_phase), .minus_1(minus_1), .seven_num(seven_num),
    .man_state(man1), .walk_active(walk1), .frame_wrap(wrap1), .man_visible(vis1)
  );

  // Reference model: frame index derived from strobes counted since entering the phase.
  int m_prev [2];
  int m_str  [2];
  bit m_vis  [2];
  int e_man  [2];
  bit e_wrap [2];
  bit e_walk [2];
  int fdiv   [2] = '{8, 1};

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset(input int d);
    m_prev[d] = 7;
    m_str[d]  = 0;
    m_vis[d]  = 1'b1;
    e_man[d]  = 0;
    e_wrap[d] = 1'b0;
    e_walk[d] = 1'b0;
  endtask

  task automatic model_step(input int d, input int ph, input bit m1, input int sn);
    bit chg, walk, adv;
    int div;
    chg  = (ph != m_prev[d]);
    walk = (ph == 0) || (ph == 1);
    div  = (ph == 0) ? 16 : fdiv[d];
    adv  = 1'b0;
    if (chg) m_str[d] = 0;
    else if (walk && m1) begin
      m_str[d]++;
      adv = (m_str[d] % div) == 0;
    end
    e_man[d]  = (m_str[d] / div) % 16;
    e_wrap[d] = adv && (e_man[d] == 0);
    e_walk[d] = walk;
    if (chg || !(ph == 1 && sn <= 3) || !BLINK) m_vis[d] = 1'b1;
    else if (adv) m_vis[d] = !m_vis[d];
    m_prev[d] = ph;
  endtask

  task automatic tick(input int ph, input bit m1, input int sn);
    cur_phase = 3'(ph);
    minus_1   = m1;
    seven_num = 4'(sn);
    for (int d = 0; d < 2; d++) begin
      if (!rst) model_reset(d);
      else model_step(d, ph, m1, sn);
    end
    @(posedge clk);
    #1;
    chk("model man0", int'(man0), e_man[0]);
    chk("model walk0", int'(walk0), int'(e_walk[0]));
    chk("model wrap0", int'(wrap0), int'(e_wrap[0]));
    chk("model vis0", int'(vis0), int'(m_vis[0]));
    chk("model man1", int'(man1), e_man[1]);
    chk("model walk1", int'(walk1), int'(e_walk[1]));
    chk("model wrap1", int'(wrap1), int'(e_wrap[1]));
    chk("model vis1", int'(vis1), int'(m_vis[1]));
  endtask

  typedef struct {
    int ph;
    bit m1;
    int cnt;
    int e_man;
    bit e_walk;
    bit e_wrap;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int ph;
    vecs[0]  = '{0, 1'b0,   1,  0, 1'b1, 1'b0};
    vecs[1]  = '{0, 1'b1,  15,  0, 1'b1, 1'b0};
    vecs[2]  = '{0, 1'b1,   1,  1, 1'b1, 1'b0};
    vecs[3]  = '{1, 1'b0,   1,  0, 1'b1, 1'b0};
    vecs[4]  = '{1, 1'b1, 127, 15, 1'b1, 1'b0};
    vecs[5]  = '{1, 1'b1,   1,  0, 1'b1, 1'b1};
    vecs[6]  = '{1, 1'b0,   1,  0, 1'b1, 1'b0};
    vecs[7]  = '{0, 1'b0,   1,  0, 1'b1, 1'b0};
    vecs[8]  = '{0, 1'b1,  80,  5, 1'b1, 1'b0};
    vecs[9]  = '{2, 1'b1,   1,  0, 1'b0, 1'b0};
    vecs[10] = '{2, 1'b1,  10,  0, 1'b0, 1'b0};
    vecs[11] = '{0, 1'b1,   1,  0, 1'b1, 1'b0};

    rst = 1'b0; cur_phase = 3'd0; minus_1 = 1'b0; seven_num = 4'd7;
    model_reset(0); model_reset(1);
    repeat (2) @(posedge clk);
    #1;
    chk("reset man", int'(man0), 0);
    chk("reset walk", int'(walk0), 0);
    chk("reset wrap", int'(wrap0), 0);
    chk("reset vis", int'(vis0), 1);
    rst = 1'b1;

    for (int i = 0; i < 12; i++) begin
      for (int c = 0; c < vecs[i].cnt; c++) tick(vecs[i].ph, vecs[i].m1, 7);
      chk($sformatf("vec%0d man", i), int'(man0), vecs[i].e_man);
      chk($sformatf("vec%0d walk", i), int'(walk0), int'(vecs[i].e_walk));
      chk($sformatf("vec%0d wrap", i), int'(wrap0), int'(vecs[i].e_wrap));
    end

    // FAST_DIV=0 instance advances on every strobe
    tick(2, 1'b0, 7);
    tick(1, 1'b0, 7);
    for (int k = 1; k <= 3; k++) begin
      tick(1, 1'b1, 7);
      chk($sformatf("div0 man step%0d", k), int'(man1), k);
      chk($sformatf("div8 man step%0d", k), int'(man0), 0);
    end

    // Blink: no toggle at seven_num=5, toggles at 3 (constant 1 without the feature)
    tick(2, 1'b0, 5);
    tick(1, 1'b0, 5);
    for (int f = 0; f < 4; f++) begin
      repeat (8) tick(1, 1'b1, 5);
      chk($sformatf("blink sn5 f%0d", f), int'(vis0), 1);
    end
    for (int f = 0; f < 4; f++) begin
      repeat (8) tick(1, 1'b1, 3);
      chk($sformatf("blink sn3 f%0d", f), int'(vis0), BLINK ? (f % 2) : 1);
    end

    // Reset mid-frame at man_state=9, presc=4
    tick(2, 1'b0, 7);
    tick(1, 1'b0, 7);
    repeat (76) tick(1, 1'b1, 7);
    chk("pre-reset man", int'(man0), 9);
    #2 rst = 1'b0;
    #1;
    chk("async rst man", int'(man0), 0);
    chk("async rst walk", int'(walk0), 0);
    chk("async rst wrap", int'(wrap0), 0);
    chk("async rst vis", int'(vis0), 1);
    chk("async rst man1", int'(man1), 0);
    tick(1, 1'b1, 7);
    tick(1, 1'b1, 7);
    rst = 1'b1;
    tick(1, 1'b1, 7);
    chk("post-rst change man", int'(man0), 0);
    repeat (7) tick(1, 1'b1, 7);
    chk("post-rst 7 strobes", int'(man0), 0);
    tick(1, 1'b1, 7);
    chk("post-rst 8 strobes", int'(man0), 1);

    // Randomized traffic with occasional phase changes
    ph = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(63) == 0) ph = int'($urandom_range(3));
      tick(ph, $urandom_range(3) != 0, int'($urandom_range(7)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
